// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared constants and state encodings for the UART program loader
package loader_pkg;

    localparam int DEF_CLK_DIV   = 16;
    localparam int DEF_MEM_DEPTH = 24;
    localparam int BYTE_W        = 8;

    localparam logic [1:0] RX_IDLE_E  = 2'd0;
    localparam logic [1:0] RX_START_E = 2'd1;
    localparam logic [1:0] RX_DATA_E  = 2'd2;
    localparam logic [1:0] RX_STOP_E  = 2'd3;

    localparam logic [1:0] L_LEN_E  = 2'd0;
    localparam logic [1:0] L_DATA_E = 2'd1;
    localparam logic [1:0] L_DONE_E = 2'd2;

    typedef enum logic [1:0] {
        RX_IDLE  = RX_IDLE_E,
        RX_START = RX_START_E,
        RX_DATA  = RX_DATA_E,
        RX_STOP  = RX_STOP_E
    } rx_state_t;

    typedef enum logic [1:0] {
        L_LEN  = L_LEN_E,
        L_DATA = L_DATA_E,
        L_DONE = L_DONE_E
    } ld_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART byte receiver with input synchroniser
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   rx          - raw serial line, idles high
//   byte_valid  - one-cycle strobe, byte_data valid while high (held until next frame)
//   byte_data   - received byte, LSB first on the line
//   frame_err   - one-cycle pulse when the stop bit samples low
module uart_rx_byte
    import loader_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic              byte_valid,
    output logic [BYTE_W-1:0] byte_data,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLK_DIV - 1);

    logic              rx_meta_q, rx_s_q;
    rx_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    // After a bad stop bit the line may still be low (break); hold here until it rises
    logic              hold_q, hold_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        hold_d  = hold_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!rx_s_q) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    // Line high at mid start bit means it was only a glitch
                    state_d = rx_s_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[BYTE_W-1:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (hold_q) begin
                    if (rx_s_q) begin
                        hold_d  = 1'b0;
                        state_d = RX_IDLE;
                    end
                end else if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        valid_d = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        ferr_d = 1'b1;
                        hold_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            hold_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            hold_q    <= hold_d;
        end
    end

    assign byte_valid = valid_q;
    assign byte_data  = shift_q;
    assign frame_err  = ferr_q;

endmodule

// File: rtl/prog_loader_uart.sv
// rtl/prog_loader_uart.sv - length-prefixed UART program loader for instruction memory
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   rx                  - UART receive line
//   rearm               - pulse in DONE to start a new load
//   mem_we/addr/data    - instruction-memory write port
//   load_busy/load_done - load in progress / load complete
//   frame_err, len_err  - sticky error flags, cleared by rearm
module prog_loader_uart
    import loader_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int ADDR_W    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    input  logic              rearm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              load_busy,
    output logic              load_done,
    output logic              frame_err,
    output logic              len_err
);

    localparam logic [7:0] DEPTH_B = 8'(MEM_DEPTH);

    logic              byte_valid;
    logic [BYTE_W-1:0] byte_data;
    logic              rx_ferr;

    uart_rx_byte #(.CLK_DIV(CLK_DIV)) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (rx_ferr)
    );

    ld_state_t         state_q, state_d;
    logic [7:0]        rem_q, rem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              we_q, we_d;
    logic              ferr_q, ferr_d;
    logic              lerr_q, lerr_d;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        ferr_d  = ferr_q | rx_ferr;
        lerr_d  = lerr_q;
        case (state_q)
            L_LEN: begin
                if (byte_valid) begin
                    if (byte_data != 8'd0 && byte_data <= DEPTH_B) begin
                        rem_d   = byte_data;
                        addr_d  = '0;
                        state_d = L_DATA;
                    end else begin
                        lerr_d = 1'b1;
                    end
                end
            end
            L_DATA: begin
                if (byte_valid) begin
                    we_d   = 1'b1;
                    data_d = byte_data;
                end
                // Bookkeeping happens during the write cycle so the new address
                // appears the cycle after; the last write leaves the address
                // parked on the final location.
                if (we_q) begin
                    rem_d = rem_q - 8'd1;
                    if (rem_q == 8'd1) state_d = L_DONE;
                    else               addr_d  = addr_q + ADDR_W'(1);
                end
            end
            L_DONE: begin
                if (rearm) begin
                    state_d = L_LEN;
                    ferr_d  = 1'b0;
                    lerr_d  = 1'b0;
                end
            end
            default: state_d = L_LEN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= L_LEN;
            rem_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            ferr_q  <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            ferr_q  <= ferr_d;
            lerr_q  <= lerr_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_data  = data_q;
    assign load_busy = (state_q == L_DATA);
    assign load_done = (state_q == L_DONE);
    assign frame_err = ferr_q;
    assign len_err   = lerr_q;

endmodule
